// File: rtl/common_pkg.sv
// Shared types and encodings for the multicycle control path: opcodes,
// controller state names and ALU operation codes.
package common_pkg;

    typedef logic [6:0] opcode_t;

    localparam opcode_t OPC_RTYPE  = 7'b0110011;
    localparam opcode_t OPC_LOAD   = 7'b0000011;
    localparam opcode_t OPC_STORE  = 7'b0100011;
    localparam opcode_t OPC_BRANCH = 7'b1100011;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        FETCH     = 3'd1,
        DECODE    = 3'd2,
        EXECUTE   = 3'd3,
        MEM       = 3'd4,
        WRITEBACK = 3'd5,
        TRAP      = 3'd6
    } ctrl_state_t;

    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

    // True for the four instruction classes this controller knows how to sequence.
    function automatic logic is_legal(input opcode_t op);
        return (op == OPC_RTYPE) || (op == OPC_LOAD) ||
               (op == OPC_STORE) || (op == OPC_BRANCH);
    endfunction

endpackage

// File: rtl/main_decoder.sv
// Combinational control decode: turns the current controller state and the
// latched opcode into datapath strobes. Only the commit strobes look at the
// live mem_ready / zero-flag inputs.
module main_decoder
    import common_pkg::*;
(
    input  ctrl_state_t i_state,
    input  opcode_t     i_opcode_q,
    input  logic        i_mem_ready,
    input  logic        i_alu_zero,
    output logic        o_ir_w,
    output logic        o_pc_w,
    output logic        o_branch_taken,
    output logic [1:0]  o_alu_op,
    output logic        o_alu_src,
    output logic        o_reg_w,
    output logic        o_mem_w,
    output logic        o_mem_r,
    output logic        o_mem_to_reg
);

    // Per-state control outputs; everything idles at zero unless a state claims it.
    always_comb begin
        o_ir_w         = 1'b0;
        o_pc_w         = 1'b0;
        o_branch_taken = 1'b0;
        o_alu_op       = ALU_OP_ADD;
        o_alu_src      = 1'b0;
        o_reg_w        = 1'b0;
        o_mem_w        = 1'b0;
        o_mem_r        = 1'b0;
        o_mem_to_reg   = 1'b0;
        case (i_state)
            FETCH: begin
                o_ir_w = 1'b1;
            end
            EXECUTE: begin
                case (i_opcode_q)
                    OPC_RTYPE: begin
                        o_alu_op = ALU_OP_FUNCT;
                    end
                    OPC_LOAD, OPC_STORE: begin
                        o_alu_op  = ALU_OP_ADD;
                        o_alu_src = 1'b1;
                    end
                    OPC_BRANCH: begin
                        o_alu_op       = ALU_OP_SUB;
                        o_pc_w         = 1'b1;
                        o_branch_taken = i_alu_zero;
                    end
                    default: begin
                        o_alu_op = ALU_OP_ADD;
                    end
                endcase
            end
            MEM: begin
                o_alu_op  = ALU_OP_ADD;
                o_alu_src = 1'b1;
                o_mem_r   = (i_opcode_q == OPC_LOAD);
                o_mem_w   = (i_opcode_q == OPC_STORE);
                o_pc_w    = (i_opcode_q == OPC_STORE) && i_mem_ready;
            end
            WRITEBACK: begin
                o_reg_w      = 1'b1;
                o_pc_w       = 1'b1;
                o_mem_to_reg = (i_opcode_q == OPC_LOAD);
            end
            default: begin
                o_ir_w = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle instruction sequencer: FETCH/DECODE/EXECUTE/MEM/WRITEBACK FSM
// with a sticky trap on unknown opcodes plus active-cycle and retired-
// instruction counters. Output decode lives in main_decoder.
module multicycle_controller
    import common_pkg::*;
#(
    parameter int COUNT_WIDTH = 32
)
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   run,
    input  opcode_t                opcode,
    input  logic                   ALU_zero_flag,
    input  logic                   mem_ready,
    output logic                   ctrl_ir_w,
    output logic                   ctrl_pc_w,
    output logic                   ctrl_branch_taken,
    output logic [1:0]             ctrl_ALU_op,
    output logic                   ctrl_ALU_src,
    output logic                   ctrl_reg_w,
    output logic                   ctrl_mem_w,
    output logic                   ctrl_mem_r,
    output logic                   ctrl_mem_to_reg,
    output logic                   illegal,
    output ctrl_state_t            state,
    output logic [COUNT_WIDTH-1:0] cycle_count,
    output logic [COUNT_WIDTH-1:0] instret_count
);

    ctrl_state_t            r_state;
    ctrl_state_t            w_next_state;
    opcode_t                r_opcode_q;
    logic                   r_illegal;
    logic [COUNT_WIDTH-1:0] r_cycle_count;
    logic [COUNT_WIDTH-1:0] r_instret_count;
    logic                   w_pc_w;
    logic                   w_after_retire_fetch;

    // Where to go once an instruction retires: keep going only while run is high.
    assign w_after_retire_fetch = run;

    // State register; reset abandons whatever instruction was in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; post-decode decisions use the latched opcode only.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (run) begin
                    w_next_state = FETCH;
                end
            end
            FETCH: begin
                w_next_state = DECODE;
            end
            DECODE: begin
                w_next_state = is_legal(opcode) ? EXECUTE : TRAP;
            end
            EXECUTE: begin
                case (r_opcode_q)
                    OPC_RTYPE:           w_next_state = WRITEBACK;
                    OPC_LOAD, OPC_STORE: w_next_state = MEM;
                    OPC_BRANCH:          w_next_state = w_after_retire_fetch ? FETCH : IDLE;
                    default:             w_next_state = TRAP;
                endcase
            end
            MEM: begin
                if (mem_ready) begin
                    if (r_opcode_q == OPC_LOAD) begin
                        w_next_state = WRITEBACK;
                    end else begin
                        w_next_state = w_after_retire_fetch ? FETCH : IDLE;
                    end
                end
            end
            WRITEBACK: begin
                w_next_state = w_after_retire_fetch ? FETCH : IDLE;
            end
            TRAP: begin
                w_next_state = TRAP;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Capture the opcode during DECODE and raise the sticky illegal flag on an unknown one.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_opcode_q <= '0;
            r_illegal  <= 1'b0;
        end else if (r_state == DECODE) begin
            r_opcode_q <= opcode;
            if (!is_legal(opcode)) begin
                r_illegal <= 1'b1;
            end
        end
    end

    // Active-cycle counter (frozen in IDLE and TRAP) and retire counter (ticks with pc_w).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cycle_count   <= '0;
            r_instret_count <= '0;
        end else begin
            if ((r_state != IDLE) && (r_state != TRAP)) begin
                r_cycle_count <= r_cycle_count + COUNT_WIDTH'(1);
            end
            if (w_pc_w) begin
                r_instret_count <= r_instret_count + COUNT_WIDTH'(1);
            end
        end
    end

    main_decoder u_main_decoder (
        .i_state        (r_state),
        .i_opcode_q     (r_opcode_q),
        .i_mem_ready    (mem_ready),
        .i_alu_zero     (ALU_zero_flag),
        .o_ir_w         (ctrl_ir_w),
        .o_pc_w         (w_pc_w),
        .o_branch_taken (ctrl_branch_taken),
        .o_alu_op       (ctrl_ALU_op),
        .o_alu_src      (ctrl_ALU_src),
        .o_reg_w        (ctrl_reg_w),
        .o_mem_w        (ctrl_mem_w),
        .o_mem_r        (ctrl_mem_r),
        .o_mem_to_reg   (ctrl_mem_to_reg)
    );

    assign ctrl_pc_w     = w_pc_w;
    assign illegal       = r_illegal;
    assign state         = r_state;
    assign cycle_count   = r_cycle_count;
    assign instret_count = r_instret_count;

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 SHALL have parameter COUNT_WIDTH, default 32, width of the cycle and retired-instruction counters.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port run  input  1  execution enable; level-sensitive.
REQ-005 SHALL have port opcode  input  opcode_t (7)  instruction[6:0] from instruction memory.
REQ-006 SHALL have port ALU_zero_flag  input  1  ALU zero result.
REQ-007 SHALL have port mem_ready  input  1  data memory completion acknowledge.
REQ-008 SHALL have port ctrl_ir_w  output  1  instruction/opcode latch enable.
REQ-009 SHALL have port ctrl_pc_w  output  1  program counter update strobe.
REQ-010 SHALL have port ctrl_branch_taken  output  1  PC selects PC+offset on ctrl_pc_w.
REQ-011 SHALL have ports ctrl_ALU_op (2), ctrl_ALU_src, ctrl_reg_w, ctrl_mem_w, ctrl_mem_r, ctrl_mem_to_reg  output  datapath controls, same meaning as the single-cycle control unit.
REQ-012 SHALL have port illegal  output  1  sticky unsupported-opcode flag.
REQ-013 SHALL have port state  output  ctrl_state_t  current FSM state, for debug.
REQ-014 SHALL have ports cycle_count, instret_count  output  COUNT_WIDTH  active cycles / retired instructions.

Function
REQ-015 SHALL implement states IDLE, FETCH, DECODE, EXECUTE, MEM, WRITEBACK, TRAP.
REQ-016 IDLE: all ctrl outputs 0; run=1 -> FETCH next cycle, else stay.
REQ-017 FETCH: ctrl_ir_w=1 for exactly one cycle; -> DECODE.
REQ-018 DECODE: latch opcode into internal opcode_q; R-type/load/store/branch -> EXECUTE; any other value -> TRAP, illegal=1.
REQ-019 Controls in EXECUTE/MEM/WRITEBACK SHALL decode from opcode_q only, never from the live opcode input.
REQ-020 EXECUTE: ALU_op=10/src=0 for R-type; ALU_op=00/src=1 for load/store; ALU_op=01/src=0 for branch.
REQ-021 EXECUTE R-type -> WRITEBACK; load/store -> MEM.
REQ-022 EXECUTE branch: ctrl_pc_w=1, ctrl_branch_taken=ALU_zero_flag, instruction retires; -> FETCH if run=1, else IDLE.
REQ-023 MEM: ctrl_mem_r (load) or ctrl_mem_w (store) held with ALU controls as EXECUTE until mem_ready=1; no timeout; unbounded stall.
REQ-024 MEM with mem_ready=1: load -> WRITEBACK; store asserts ctrl_pc_w, retires, -> FETCH/IDLE per run.
REQ-025 WRITEBACK: ctrl_reg_w=1, ctrl_mem_to_reg=1 for load else 0, ctrl_pc_w=1, retires; -> FETCH/IDLE per run.
REQ-026 ctrl_pc_w SHALL pulse exactly once per retired instruction; ctrl_branch_taken=0 whenever ctrl_pc_w=0.
REQ-027 run=0 mid-instruction SHALL NOT abort; current instruction completes, then IDLE.
REQ-028 TRAP: all ctrl outputs 0, illegal=1, state held until reset; run ignored.
REQ-029 cycle_count SHALL increment every cycle in states other than IDLE and TRAP; wraps modulo 2^COUNT_WIDTH.
REQ-030 instret_count SHALL increment in the retire cycle (same cycle as ctrl_pc_w); wraps modulo 2^COUNT_WIDTH.
REQ-031 All outputs SHALL be registered state plus combinational decode of state and opcode_q; no combinational path from mem_ready or ALU_zero_flag to anything except state transition, ctrl_pc_w and ctrl_branch_taken.

Reset
REQ-032 rst=0 SHALL immediately force state=IDLE, opcode_q=0, illegal=0, both counters=0, all ctrl outputs 0, independent of clk.
REQ-033 Reset asserted in any state, including MEM stall and TRAP, SHALL abandon the instruction with no ctrl_pc_w/ctrl_reg_w pulse.
REQ-034 After rst release, first FETCH SHALL occur one cycle after the first edge sampling run=1.

Structure
REQ-035 ctrl_state_t and ALU_op encodings (ALU_OP_ADD=00, ALU_OP_SUB=01, ALU_OP_FUNCT=10) SHALL live in common_pkg; opcode_t reused from common_pkg.
REQ-036 Sub-module main_decoder (combinational opcode_q + state -> ctrl outputs) SHALL be separate; FSM and counters stay in multicycle_controller.

Verification
REQ-037 R-type add, run=1, mem_ready=1: FETCH,DECODE,EXECUTE,WRITEBACK; reg_w=1 in cycle 4; instret 0->1; cycle_count=4.
REQ-038 Load with mem_ready low 3 cycles: mem_r held 4 MEM cycles, then WRITEBACK mem_to_reg=1; cycle_count=8 at retire.
REQ-039 Branch with ALU_zero_flag=1 then =0: pc_w=1 both times, branch_taken 1 then 0; no reg_w, no mem access.
REQ-040 Opcode 7'b1111111 at DECODE: TRAP, illegal=1, counters frozen; 10 cycles later unchanged; rst=0 -> IDLE, illegal=0.
REQ-041 Store, run dropped in EXECUTE: store completes on mem_ready, mem_w asserted, instret=1, state IDLE, no further FETCH.
REQ-042 rst=0 asynchronously mid-MEM stall: all outputs 0 before next clk edge; cycle_count=0; no pc_w pulse.
